// File: rtl/serial_paralelo_rx_if.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx_if
// Bundles the signals of one RX lane deserializer.
//   data_in     : serial bit stream, MSB first (driven by the line side)
//   data_out    : last received non-COM byte
//   valid_out   : data_out holds a byte received in the current byte period
//   byte_strobe : one-cycle pulse after each aligned byte boundary
//   active      : lane aligned and locked
// Modports:
//   master : line side plus downstream consumer (drives data_in, reads the rest)
//   slave  : the deserializer itself
// ---------------------------------------------------------------------------
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
// Per-lane receive deserializer. Takes the MSB-first serial stream on
// clk_32f, finds byte alignment on the COM idle symbol, locks after
// COM_TARGET consecutive aligned COMs and then delivers data bytes with a
// valid flag. One byte period is 8 clk_32f cycles. All outputs are
// registered.
// Ports:
//   clk_32f : bit clock, rising edge
//   reset   : synchronous, active-high
//   bus     : serial_paralelo_rx_if.slave (data_in, data_out, valid_out,
//             byte_strobe, active)
// ---------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter int         COM_TARGET = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_rx_if.slave  bus
);

    localparam int CW = $clog2(COM_TARGET + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   com_cnt_q, com_cnt_d;
    logic [CW-1:0]   com_inc;

    // Only the 7 most recent past bits are ever consumed: the current bit
    // completes the 8-bit window combinationally.
    logic [6:0]      hist_q;
    logic [7:0]      win;
    logic            is_com;
    logic            boundary;

    logic [7:0]      data_p1, data_d;
    logic            vld_p1, vld_d;
    logic            strobe_p1, strobe_d;
    logic            active_p1, active_d;

    assign win      = {hist_q, bus.data_in};
    assign is_com   = (win == COM_SYM);
    assign boundary = (state_q != SEARCH) && (bit_cnt_q == 3'd7);
    assign com_inc  = com_cnt_q + CW'(1);

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_p1;
        vld_d     = vld_p1;
        strobe_d  = 1'b0;
        active_d  = active_p1;

        unique case (state_q)
            SEARCH: begin
                // Bit-granular hunt: any offset may produce the match.
                if (is_com) begin
                    state_d   = ALIGN;
                    bit_cnt_d = 3'd0;
                    com_cnt_d = CW'(1);
                end
            end

            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_com && (com_inc == CW'(COM_TARGET))) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else if (is_com) begin
                        com_cnt_d = com_inc;
                    end else begin
                        // The failing window is not re-examined as a
                        // potential new match; hunting resumes next cycle.
                        state_d   = SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_com) begin
                        vld_d = 1'b0;
                    end else begin
                        data_d = win;
                        vld_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= SEARCH;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= '0;
            hist_q    <= 7'd0;
            data_p1   <= 8'h00;
            vld_p1    <= 1'b0;
            strobe_p1 <= 1'b0;
            active_p1 <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            hist_q    <= win[6:0];
            data_p1   <= data_d;
            vld_p1    <= vld_d;
            strobe_p1 <= strobe_d;
            active_p1 <= active_d;
        end
    end

    assign bus.data_out    = data_p1;
    assign bus.valid_out   = vld_p1;
    assign bus.byte_strobe = strobe_p1;
    assign bus.active      = active_p1;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Directed bench for the RX lane deserializer. Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point, so every
// sample reflects the edge that consumed the most recent bit.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    logic clk_32f;
    logic reset;

    serial_paralelo_rx_if bus ();

    serial_paralelo_rx #(
        .COM_SYM    (8'hBC),
        .COM_TARGET (4)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int         pass_n;
    int         chk_n;
    int         strobe_cnt;
    logic       vld_first;
    logic [7:0] dat_first;

    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Sends the low n bits of val, most significant of those first.
    task automatic send_bits(input logic [7:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    // Sends one byte MSB first; records strobes seen and the outputs sampled
    // after the first bit so callers can check hold behaviour.
    task automatic send_byte(input logic [7:0] b);
        strobe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (bus.byte_strobe === 1'b1) strobe_cnt++;
            if (i == 7) begin
                vld_first = bus.valid_out;
                dat_first = bus.data_out;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            chk_n++;
            if ({bus.data_out, bus.valid_out, bus.active, bus.byte_strobe} !== 11'd0)
                $display("FAIL reset_hold[%0d]: data=%h valid=%b active=%b strobe=%b, want all 0",
                         c, bus.data_out, bus.valid_out, bus.active, bus.byte_strobe);
            else pass_n++;
        end
        reset = 1'b0;
    endtask

    task automatic test_acquire;
        send_byte(8'hBC);
        chk_n++;
        if (strobe_cnt !== 0) $display("FAIL acq_search_strobe: got %0d want 0", strobe_cnt);
        else pass_n++;
        send_byte(8'hBC);
        chk_n++;
        if (strobe_cnt !== 1 || bus.byte_strobe !== 1'b1)
            $display("FAIL acq_align_strobe: cnt=%0d now=%b want 1/1", strobe_cnt, bus.byte_strobe);
        else pass_n++;
        send_byte(8'hBC);
        send_bits(8'h5E, 7);
        chk_n++;
        if (bus.active !== 1'b0) $display("FAIL acq_early_active: got %b want 0", bus.active);
        else pass_n++;
        send_bit(1'b0);
        chk_n++;
        if (bus.active !== 1'b1) $display("FAIL acq_active: got %b want 1", bus.active);
        else pass_n++;
        chk_n++;
        if (bus.valid_out !== 1'b0 || bus.byte_strobe !== 1'b1)
            $display("FAIL acq_lock_outputs: valid=%b strobe=%b want 0/1", bus.valid_out, bus.byte_strobe);
        else pass_n++;
    endtask

    task automatic test_data;
        send_byte(8'hA5);
        chk_n++;
        if (bus.data_out !== 8'hA5 || bus.valid_out !== 1'b1)
            $display("FAIL data_a5: data=%h valid=%b want a5/1", bus.data_out, bus.valid_out);
        else pass_n++;
        chk_n++;
        if (strobe_cnt !== 1 || bus.byte_strobe !== 1'b1)
            $display("FAIL data_a5_strobe: cnt=%0d now=%b want 1/1", strobe_cnt, bus.byte_strobe);
        else pass_n++;
        send_byte(8'h3C);
        chk_n++;
        if (dat_first !== 8'hA5 || vld_first !== 1'b1)
            $display("FAIL data_a5_hold: data=%h valid=%b want a5/1", dat_first, vld_first);
        else pass_n++;
        chk_n++;
        if (bus.data_out !== 8'h3C || bus.valid_out !== 1'b1 || strobe_cnt !== 1)
            $display("FAIL data_3c: data=%h valid=%b strobes=%0d want 3c/1/1",
                     bus.data_out, bus.valid_out, strobe_cnt);
        else pass_n++;
        send_byte(8'hBC);
        chk_n++;
        if (vld_first !== 1'b1) $display("FAIL data_3c_hold: valid=%b want 1", vld_first);
        else pass_n++;
        chk_n++;
        if (bus.data_out !== 8'h3C || bus.valid_out !== 1'b0 || strobe_cnt !== 1)
            $display("FAIL data_com_idle: data=%h valid=%b strobes=%0d want 3c/0/1",
                     bus.data_out, bus.valid_out, strobe_cnt);
        else pass_n++;
        send_byte(8'hFF);
        chk_n++;
        if (bus.data_out !== 8'hFF || bus.valid_out !== 1'b1 || strobe_cnt !== 1 || bus.active !== 1'b1)
            $display("FAIL data_ff: data=%h valid=%b strobes=%0d active=%b want ff/1/1/1",
                     bus.data_out, bus.valid_out, strobe_cnt, bus.active);
        else pass_n++;
    endtask

    task automatic test_bit_offset;
        logic [7:0] pre;
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        pre = 8'($urandom_range(0, 7));
        send_bits(pre, 3);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk_n++;
        if (bus.active !== 1'b1) $display("FAIL offset_active: got %b want 1", bus.active);
        else pass_n++;
        send_byte(8'h5A);
        chk_n++;
        if (bus.data_out !== 8'h5A || bus.valid_out !== 1'b1)
            $display("FAIL offset_data: data=%h valid=%b want 5a/1", bus.data_out, bus.valid_out);
        else pass_n++;
    endtask

    task automatic test_false_com;
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        send_byte(8'hBC);
        send_byte(8'h00);
        chk_n++;
        if (bus.byte_strobe !== 1'b1 || bus.active !== 1'b0)
            $display("FAIL false_com_exit: strobe=%b active=%b want 1/0", bus.byte_strobe, bus.active);
        else pass_n++;
        send_byte(8'h00);
        chk_n++;
        if (strobe_cnt !== 0 || bus.active !== 1'b0)
            $display("FAIL false_com_search: strobes=%0d active=%b want 0/0", strobe_cnt, bus.active);
        else pass_n++;
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk_n++;
        if (bus.active !== 1'b0) $display("FAIL false_com_3: active=%b want 0", bus.active);
        else pass_n++;
        send_byte(8'hBC);
        chk_n++;
        if (bus.active !== 1'b1) $display("FAIL false_com_relock: active=%b want 1", bus.active);
        else pass_n++;
    endtask

    task automatic test_mid_reset;
        send_byte(8'h11);
        chk_n++;
        if (bus.data_out !== 8'h11 || bus.valid_out !== 1'b1)
            $display("FAIL mid_pre: data=%h valid=%b want 11/1", bus.data_out, bus.valid_out);
        else pass_n++;
        send_bits(8'h02, 4);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        chk_n++;
        if ({bus.data_out, bus.valid_out, bus.active, bus.byte_strobe} !== 11'd0)
            $display("FAIL mid_reset: data=%h valid=%b active=%b strobe=%b want all 0",
                     bus.data_out, bus.valid_out, bus.active, bus.byte_strobe);
        else pass_n++;
        // Three COMs then data: lock not reached, so no data is delivered.
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h77);
        chk_n++;
        if (bus.valid_out !== 1'b0 || bus.active !== 1'b0 || bus.data_out !== 8'h00)
            $display("FAIL mid_partial: data=%h valid=%b active=%b want 00/0/0",
                     bus.data_out, bus.valid_out, bus.active);
        else pass_n++;
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk_n++;
        if (bus.active !== 1'b1 || bus.valid_out !== 1'b0)
            $display("FAIL mid_relock: active=%b valid=%b want 1/0", bus.active, bus.valid_out);
        else pass_n++;
        send_byte(8'h66);
        chk_n++;
        if (bus.data_out !== 8'h66 || bus.valid_out !== 1'b1)
            $display("FAIL mid_data: data=%h valid=%b want 66/1", bus.data_out, bus.valid_out);
        else pass_n++;
    endtask

    initial begin
        pass_n      = 0;
        chk_n       = 0;
        strobe_cnt  = 0;
        vld_first   = 1'b0;
        dat_first   = 8'h00;
        reset       = 1'b1;
        bus.data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        test_reset();
        test_acquire();
        test_data();
        test_bit_offset();
        test_false_com();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Per-lane receive deserializer for the PHY RX path. It is the counterpart of the per-lane parallel-to-serial stage. It takes the 1-bit MSB-first serial stream on clk_32f and acquires byte alignment on the COM idle symbol (8'hBC). It then delivers 8-bit data bytes with a valid flag to the downstream 8b-to-32b merge and un-striping logic. Everything runs on clk_32f; one byte period is 8 clk_32f cycles.

Parameters:
COM_SYM, 8'hBC, idle/alignment symbol sent by TX whenever its valid is low.
COM_TARGET, 4, consecutive aligned COM bytes, including the first match, required to declare the lane active.

Ports:
clk_32f  input  1  bit clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high.
data_in  input  1  serial bit stream, MSB first.
data_out  output  8  last received non-COM byte; held between updates.
valid_out  output  1  high while data_out holds a data byte received in the current byte period.
byte_strobe  output  1  one-cycle pulse at each aligned byte boundary (ALIGN or ACTIVE).
active  output  1  lane aligned and locked.

Behaviour:
- Reset (reset=1 at a clock edge):
  - data_out=8'h00; valid_out, byte_strobe and active = 0.
  - state=SEARCH, bit_cnt=0, com_cnt=0, shift_reg=8'h00.
  - Reset wins over every other event, including mid-byte and while ACTIVE.
- Shift register, every non-reset cycle: shift_reg <= {shift_reg[6:0], data_in}.
- Window: win = {shift_reg[6:0], data_in}, i.e. the 8 most recent bits including the current one.
- SEARCH:
  - Each cycle, if win==COM_SYM: go to ALIGN, bit_cnt<=0, com_cnt<=1. This match is bit-granular and works at any bit offset.
  - No data output in this state.
- Bit counter (ALIGN and ACTIVE): if bit_cnt==7, the cycle is a byte boundary and win is the complete byte; bit_cnt<=0. Otherwise bit_cnt<=bit_cnt+1.
  - The first boundary after a SEARCH match falls exactly 8 cycles after the match cycle.
- ALIGN, at each boundary:
  - win==COM_SYM and com_cnt+1==COM_TARGET: go to ACTIVE, active<=1.
  - win==COM_SYM otherwise: com_cnt<=com_cnt+1.
  - win!=COM_SYM: go to SEARCH, com_cnt<=0. The mismatching cycle is not itself re-checked for a COM match.
- ACTIVE, at each boundary:
  - win!=COM_SYM: data_out<=win, valid_out<=1.
  - win==COM_SYM: valid_out<=0, data_out holds.
  - valid_out and data_out hold until the next boundary (8 cycles).
  - ACTIVE is only left by reset. There is no loss-of-lock detection in this block.
- byte_strobe:
  - Registered; equals 1 in the cycle after each boundary in ALIGN or ACTIVE, else 0.
  - Also pulses on the boundary that causes the ALIGN->ACTIVE or ALIGN->SEARCH transition.
- Latency: last bit of a byte on data_in at cycle n -> data_out/valid_out/byte_strobe updated and visible at cycle n+1.
- Outputs are registered only; no combinational path from data_in to any output.
- A COM pattern that appears at a non-boundary offset while in ALIGN or ACTIVE is ignored.

Test Plan:
- Reset hold: reset=1 for 5 cycles with random data_in -> data_out=8'h00, valid_out=0, active=0, byte_strobe=0 throughout.
- Clean acquisition: continuous 8'hBC stream, first COM's last bit at cycle t -> active rises at t+25 (4th COM ends t+24); valid_out stays 0.
- Data after lock: after active, send 8'hA5, 8'h3C, 8'hBC, 8'hFF.
  - data_out=8'hA5 then 8'h3C, each with valid_out=1 for 8 cycles.
  - Then valid_out=0 with data_out holding 8'h3C.
  - Then 8'hFF with valid_out=1.
  - byte_strobe pulses every 8 cycles.
- Bit-offset acquisition: prefix 3 random bits before the COM stream -> lock achieved and bytes recovered correctly, i.e. a following 8'h5A appears on data_out.
- False COM: one 8'hBC followed by 8'h00 -> return to SEARCH, active stays 0; a following clean run of 4 COMs locks.
- Reset mid-operation: reset=1 for one cycle during a data byte while ACTIVE -> next cycle all outputs at reset values; full re-acquisition of 4 COMs is required before valid_out rises again.
